// File: rtl/acc_sequencer.sv
// Program sequencer for the 8-bit accumulator datapath: stores DEPTH opcodes and issues one
// registered control word per clock with a start/busy/done handshake. Optional LOOP opcode under ACC_SEQ_LOOP_EN.
module acc_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          CLK,
  input  logic          Clr,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [3:0]    prog_data,
  input  logic          start,
`ifdef ACC_SEQ_LOOP_EN
  input  logic [3:0]    loop_cnt,
`endif
  output logic          busy,
  output logic          done,
  output logic          V0,
  output logic          V1,
  output logic          M,
  output logic          s0,
  output logic          LSHL,
  output logic          dp_en,
  output logic [AW-1:0] pc
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [3:0]    OP_HALT   = 4'hF;

  state_t        state, state_nxt;
  logic [3:0]    mem [DEPTH];
  logic [3:0]    op;
  logic [5:0]    ctl, ctl_nxt;  // {V0, V1, M, s0, LSHL, dp_en}
  logic [AW-1:0] pc_nxt;
  logic          busy_nxt, done_nxt;
  logic          jump;
  logic [3:0]    iter, iter_nxt;

  assign op = mem[pc];
  assign {V0, V1, M, s0, LSHL, dp_en} = ctl;

  always_ff @(posedge CLK or negedge Clr) begin
    if (!Clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= OP_HALT;
    end else if (state == IDLE && prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge CLK or negedge Clr) begin
    if (!Clr) begin
      state <= IDLE;
      pc    <= '0;
      ctl   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      iter  <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ctl   <= ctl_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      iter  <= iter_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ctl_nxt   = ctl;
    busy_nxt  = busy;
    done_nxt  = done;
    iter_nxt  = iter;
    jump      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          pc_nxt    = '0;
          busy_nxt  = 1'b1;
          iter_nxt  = '0;
        end
      end
      RUN: begin
        ctl_nxt = '0;
        casez (op)
          4'b0???: ctl_nxt = {op[2], op[1], op[0], 1'b0, 1'b0, 1'b1};
          4'b1000: ctl_nxt = 6'b000101;
          4'b1001: ctl_nxt = 6'b000111;
`ifdef ACC_SEQ_LOOP_EN
          4'b1010: jump = (iter < loop_cnt);
`endif
          default: ctl_nxt = '0;
        endcase
        // A taken LOOP restarts the program even from the last address.
        if (op == OP_HALT) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else if (jump) begin
          pc_nxt   = '0;
          iter_nxt = iter + 4'd1;
        end else if (pc == LAST_ADDR) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else begin
          pc_nxt = pc + 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        ctl_nxt   = '0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        pc_nxt    = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
